// File: rtl/mac_tile_scheduler.sv
// mac_tile_scheduler
//   Issues N_TILES tile-start requests per frame to a MAC controller under a
//   credit scheme bounding the number of tiles in flight between MAC start and
//   downstream FIFO pop. Tracks results (mac_done) and pops (fifo_pop), flags
//   protocol violations, and marks the first result of a frame with sof.
//
// Ports
//   clk, rst_n        single rising-edge clock, async active-low reset
//   frame_start       one-cycle frame request (ignored while busy)
//   busy              high in ISSUE/DRAIN/DONE
//   frame_done        one-cycle pulse when the frame completes
//   mac_start_valid   tile start request (register-derived only)
//   mac_start_ready   MAC controller accepts start
//   mac_done          MAC result pulse
//   sof               start-of-frame, coincident with first mac_done of frame
//   fifo_pop          downstream FIFO pop; returns one credit
//   tile_idx          tiles issued this frame
//   credit_cnt        credits currently available
//   err_protocol      sticky protocol-violation flag
module mac_tile_scheduler #(
   parameter int TILE_SIZE = 4,
   parameter int D         = 256,
   parameter int N_TILES   = D / TILE_SIZE,
   parameter int CREDITS   = 4,
   localparam int TW       = $clog2(N_TILES + 1),
   localparam int CW       = $clog2(CREDITS + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          frame_start,
   output logic          busy,
   output logic          frame_done,
   output logic          mac_start_valid,
   input  logic          mac_start_ready,
   input  logic          mac_done,
   output logic          sof,
   input  logic          fifo_pop,
   output logic [TW-1:0] tile_idx,
   output logic [CW-1:0] credit_cnt,
   output logic          err_protocol
);

   localparam logic [TW-1:0] N_T = TW'(N_TILES);
   localparam logic [CW-1:0] CR  = CW'(CREDITS);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t        state, state_nx;
   logic [TW-1:0] tile_nx, done_cnt, done_nx, pop_cnt, pop_nx;
   logic [CW-1:0] credit_nx;
   logic          err_nx;
   logic          active, hs, done_bad, pop_bad, done_ok, pop_ok;

   assign active          = (state == ISSUE) || (state == DRAIN);
   assign busy            = (state != IDLE);
   assign frame_done      = (state == DONE);
   // Depends on registers only so the MAC side never sees a ready->valid path.
   assign mac_start_valid = (state == ISSUE) && (credit_cnt != '0) && (tile_idx < N_T);
   assign hs              = mac_start_valid && mac_start_ready;
   assign sof             = active && mac_done && (done_cnt == '0);

   // A result with no outstanding tile is spurious; a pop with every credit
   // already home has no tile behind it. Either event in IDLE is illegal.
   assign done_bad = mac_done && ((state == IDLE) || (done_cnt == tile_idx));
   assign pop_bad  = fifo_pop && ((state == IDLE) || (credit_cnt == CR));
   assign done_ok  = mac_done && !done_bad && (done_cnt != N_T);
   assign pop_ok   = fifo_pop && !pop_bad && (pop_cnt != N_T);

   always_comb begin
      state_nx  = state;
      tile_nx   = tile_idx;
      done_nx   = done_cnt;
      pop_nx    = pop_cnt;
      credit_nx = credit_cnt;
      err_nx    = err_protocol | done_bad | pop_bad;

      if (hs)      tile_nx = tile_idx + 1'b1;
      if (done_ok) done_nx = done_cnt + 1'b1;
      if (pop_ok)  pop_nx  = pop_cnt + 1'b1;

      // Start and pop in the same cycle cancel out.
      case ({hs, pop_ok})
         2'b10:   credit_nx = credit_cnt - 1'b1;
         2'b01:   credit_nx = credit_cnt + 1'b1;
         default: credit_nx = credit_cnt;
      endcase

      case (state)
         IDLE: begin
            if (frame_start) begin
               state_nx  = ISSUE;
               tile_nx   = '0;
               done_nx   = '0;
               pop_nx    = '0;
               credit_nx = CR;
               // A violation in this very cycle is still reported.
               err_nx    = done_bad | pop_bad;
            end
         end
         ISSUE: begin
            if (hs && (tile_idx == N_T - 1'b1)) state_nx = DRAIN;
         end
         DRAIN: begin
            if (pop_nx == N_T) state_nx = DONE;
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         tile_idx     <= '0;
         done_cnt     <= '0;
         pop_cnt      <= '0;
         credit_cnt   <= CR;
         err_protocol <= 1'b0;
      end else begin
         state        <= state_nx;
         tile_idx     <= tile_nx;
         done_cnt     <= done_nx;
         pop_cnt      <= pop_nx;
         credit_cnt   <= credit_nx;
         err_protocol <= err_nx;
      end
   end

endmodule

// File: tb/tb_mac_tile_scheduler.sv
// Directed bench for mac_tile_scheduler (default parameters: 64 tiles, 4 credits).
// A small responder returns mac_done a few cycles after each accepted start
// and pops the FIFO one cycle after each result; directed phases override it.
module tb_mac_tile_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_start = 1'b0;
   logic       mac_start_ready = 1'b0;
   logic       busy, frame_done, mac_start_valid, sof, err_protocol;
   logic       mac_done, fifo_pop;
   logic [6:0] tile_idx;
   logic [2:0] credit_cnt;

   logic       rsp_en = 1'b0, pop_en = 1'b0;
   logic       rsp_done = 1'b0, rsp_pop = 1'b0;
   logic       inj_done = 1'b0, inj_pop = 1'b0;
   logic [3:0] dpipe = '0;
   int         pend = 0;

   int ncmp = 0, nfail = 0;
   int start_cnt = 0, sof_cnt = 0, fd_cnt = 0;
   int s_st, s_sof, s_fd;

   assign mac_done = rsp_done | inj_done;
   assign fifo_pop = rsp_pop | inj_pop;

   always #5 clk = ~clk;

   mac_tile_scheduler dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .frame_start     (frame_start),
      .busy            (busy),
      .frame_done      (frame_done),
      .mac_start_valid (mac_start_valid),
      .mac_start_ready (mac_start_ready),
      .mac_done        (mac_done),
      .sof             (sof),
      .fifo_pop        (fifo_pop),
      .tile_idx        (tile_idx),
      .credit_cnt      (credit_cnt),
      .err_protocol    (err_protocol)
   );

   // Event counters sampled on the edge that consumes them.
   always @(posedge clk) begin
      if (mac_start_valid && mac_start_ready) start_cnt++;
      if (sof) sof_cnt++;
      if (frame_done) fd_cnt++;
   end

   // Responder: result 3 cycles after start, pop one cycle after result.
   always @(negedge clk) begin
      if (!rst_n) begin
         dpipe = '0; pend = 0; rsp_done = 1'b0; rsp_pop = 1'b0;
      end else begin
         if (rsp_done) pend++;
         dpipe    = {dpipe[2:0], (rsp_en && mac_start_valid && mac_start_ready)};
         rsp_done = dpipe[3];
         rsp_pop  = pop_en && (pend > 0);
         if (rsp_pop) pend--;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) frame_start = 1'b1;
      @(negedge clk) frame_start = 1'b0;
   endtask

   task automatic wait_fd(input int lim);
      int base = fd_cnt;
      for (int i = 0; i < lim && fd_cnt == base; i++) @(negedge clk);
      chk("frame_done_seen", (fd_cnt != base), 1);
   endtask

   task automatic snap();
      s_st = start_cnt; s_sof = sof_cnt; s_fd = fd_cnt;
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_valid", mac_start_valid, 0);
      chk("rst_sof", sof, 0);
      chk("rst_tile", tile_idx, 0);
      chk("rst_credit", credit_cnt, 4);
      chk("rst_err", err_protocol, 0);
      @(negedge clk) rst_n = 1'b1;

      // Nominal frame
      mac_start_ready = 1'b1; rsp_en = 1'b1; pop_en = 1'b1;
      snap();
      pulse_start();
      chk("nom_busy", busy, 1);
      wait_fd(2000);
      repeat (3) @(negedge clk);
      chk("nom_starts", start_cnt - s_st, 64);
      chk("nom_sof", sof_cnt - s_sof, 1);
      chk("nom_fd", fd_cnt - s_fd, 1);
      chk("nom_err", err_protocol, 0);
      chk("nom_tile", tile_idx, 64);
      chk("nom_credit", credit_cnt, 4);
      chk("nom_idle", busy, 0);

      // Extra result after the 64th: sticky error until next frame_start
      inj_done = 1'b1;
      @(negedge clk) inj_done = 1'b0;
      chk("err_extra_done", err_protocol, 1);
      repeat (3) @(negedge clk);
      chk("err_sticky", err_protocol, 1);

      // Backpressure: no pops -> only 4 starts
      pop_en = 1'b0;
      snap();
      pulse_start();
      chk("bp_err_cleared", err_protocol, 0);
      repeat (30) @(negedge clk);
      chk("bp_starts", start_cnt - s_st, 4);
      chk("bp_credit", credit_cnt, 0);
      chk("bp_valid", mac_start_valid, 0);
      chk("bp_tile", tile_idx, 4);
      pop_en = 1'b1;
      wait_fd(2000);
      repeat (3) @(negedge clk);
      chk("bp_total_starts", start_cnt - s_st, 64);
      chk("bp_fd", fd_cnt - s_fd, 1);
      chk("bp_err", err_protocol, 0);

      // Handshake hold, simultaneous start+pop, pop at full credit
      rsp_en = 1'b0; pop_en = 1'b0; mac_start_ready = 1'b0;
      pulse_start();
      chk("hold_valid0", mac_start_valid, 1);
      repeat (5) @(negedge clk);
      chk("hold_valid5", mac_start_valid, 1);
      chk("hold_tile", tile_idx, 0);
      mac_start_ready = 1'b1;
      @(negedge clk);
      chk("hold_tile_inc", tile_idx, 1);
      @(negedge clk) mac_start_ready = 1'b0;
      chk("sim_pre_credit", credit_cnt, 2);
      inj_done = 1'b1;
      #1 chk("sof_first", sof, 1);
      @(negedge clk);
      #1 chk("sof_second", sof, 0);
      @(negedge clk) inj_done = 1'b0;
      mac_start_ready = 1'b1; inj_pop = 1'b1;
      @(negedge clk) begin mac_start_ready = 1'b0; inj_pop = 1'b0; end
      chk("sim_credit", credit_cnt, 2);
      chk("sim_tile", tile_idx, 3);
      inj_pop = 1'b1;
      repeat (2) @(negedge clk);
      inj_pop = 1'b0;
      chk("pop_credit_full", credit_cnt, 4);
      chk("pop_no_err", err_protocol, 0);
      pulse_start();
      chk("busy_start_tile", tile_idx, 3);
      chk("busy_start_err", err_protocol, 0);
      inj_pop = 1'b1;
      @(negedge clk) inj_pop = 1'b0;
      chk("err_pop_full", err_protocol, 1);
      chk("err_pop_credit", credit_cnt, 4);
      repeat (3) @(negedge clk);
      chk("err_pop_sticky", err_protocol, 1);
      rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;

      // Reset mid-frame at tile 30
      rsp_en = 1'b1; pop_en = 1'b1; mac_start_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 500 && tile_idx != 7'd30; i++) @(negedge clk);
      chk("mid_reach30", tile_idx, 30);
      rst_n = 1'b0;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_valid", mac_start_valid, 0);
      chk("mid_tile", tile_idx, 0);
      chk("mid_credit", credit_cnt, 4);
      chk("mid_err", err_protocol, 0);
      chk("mid_fd", frame_done, 0);
      @(negedge clk) rst_n = 1'b1;
      snap();
      repeat (3) @(negedge clk);
      chk("post_rst_starts", start_cnt - s_st, 0);
      chk("post_rst_valid", mac_start_valid, 0);
      pulse_start();
      wait_fd(2000);
      repeat (3) @(negedge clk);
      chk("post_rst_full", start_cnt - s_st, 64);
      chk("post_rst_fd", fd_cnt - s_fd, 1);
      chk("post_rst_err", err_protocol, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
